// File: rtl/vga_timing_receiver.sv
// rtl/vga_timing_receiver.sv - VGA sync structure checker with lock FSM and pixel coordinate recovery
// Optional feature macro: VGA_RX_INPUT_SYNC_EN (two-flop input synchronizer, pin-to-output latency 4)
module vga_timing_receiver #(
  parameter int unsigned SYNC_PULSE_HORIZONTAL   = 112,
  parameter int unsigned WHOLE_LINE_HORIZONTAL   = 1688,
  parameter int unsigned BACK_PORCH_HORIZONTAL   = 248,
  parameter int unsigned VISIBLE_AREA_HORIZONTAL = 1280,
  parameter int unsigned SYNC_PULSE_VERTICAL     = 3,
  parameter int unsigned WHOLE_FRAME_VERTICAL    = 1066,
  parameter int unsigned BACK_PORCH_VERTICAL     = 38,
  parameter int unsigned VISIBLE_AREA_VERTICAL   = 1024,
  parameter int unsigned LOCK_FRAMES             = 2
) (
  input  logic        FCLK,
  input  logic        RST_IN,
  input  logic        HSYNC,
  input  logic        VSYNC,
  input  logic [2:0]  R,
  input  logic [2:0]  G,
  input  logic [1:0]  B,
  output logic [7:0]  PIXEL_DATA,
  output logic        PIXEL_VALID,
  output logic [10:0] POS_X,
  output logic [10:0] POS_Y,
  output logic        LOCKED,
  output logic        FRAME_START,
  output logic        SYNC_ERROR
);

  localparam logic [10:0] CNT_MAX     = 11'h7FF;
  localparam logic [10:0] H_SYNC      = 11'(SYNC_PULSE_HORIZONTAL);
  localparam logic [10:0] H_LINE      = 11'(WHOLE_LINE_HORIZONTAL);
  localparam logic [10:0] H_VIS_FIRST = 11'(SYNC_PULSE_HORIZONTAL + BACK_PORCH_HORIZONTAL);
  localparam logic [10:0] H_VIS_LAST  = 11'(SYNC_PULSE_HORIZONTAL + BACK_PORCH_HORIZONTAL
                                            + VISIBLE_AREA_HORIZONTAL - 1);
  localparam logic [10:0] V_SYNC      = 11'(SYNC_PULSE_VERTICAL);
  localparam logic [10:0] V_FRAME     = 11'(WHOLE_FRAME_VERTICAL);
  localparam logic [10:0] V_VIS_FIRST = 11'(SYNC_PULSE_VERTICAL + BACK_PORCH_VERTICAL);
  localparam logic [10:0] V_VIS_LAST  = 11'(SYNC_PULSE_VERTICAL + BACK_PORCH_VERTICAL
                                            + VISIBLE_AREA_VERTICAL - 1);
  localparam logic [3:0]  LOCK_N      = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // {HSYNC, VSYNC, R, G, B} as seen by the input register
  logic [9:0] pin_w;

`ifdef VGA_RX_INPUT_SYNC_EN
  logic [9:0] sync1_q;
  logic [9:0] sync2_q;

  // Two-flop synchronizer; HSYNC resets high so a source already in sync is not seen as a new edge
  always_ff @(posedge FCLK or negedge RST_IN) begin
    if (!RST_IN) begin
      sync1_q <= 10'h200;
      sync2_q <= 10'h200;
    end else begin
      sync1_q <= {HSYNC, VSYNC, R, G, B};
      sync2_q <= sync1_q;
    end
  end

  assign pin_w = sync2_q;
`else
  assign pin_w = {HSYNC, VSYNC, R, G, B};
`endif

  logic       hs_q, hs_prev_q, vs_q;
  logic [7:0] rgb_q;

  // Input register; HSYNC history resets high so the first low sample reads as a (gated) falling edge
  always_ff @(posedge FCLK or negedge RST_IN) begin
    if (!RST_IN) begin
      hs_q      <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_q      <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hs_q      <= pin_w[9];
      vs_q      <= pin_w[8];
      rgb_q     <= pin_w[7:0];
      hs_prev_q <= hs_q;
    end
  end

  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic [10:0] vs_cnt_q, vs_cnt_d;
  logic        vs_line_q, line_seen_q, frame_seen_q;
  logic        rise, fall, frame_start;
  logic        line_err, fall_err, timeout_err, frame_err, err;

  // Counts for the pixel currently in the input register, plus all sync-structure checks
  always_comb begin
    rise        = hs_q & ~hs_prev_q;
    fall        = ~hs_q & hs_prev_q;
    frame_start = rise & vs_q & ~vs_line_q;

    hcnt_d = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 11'd1;
    if (rise) hcnt_d = '0;

    vcnt_d   = vcnt_q;
    vs_cnt_d = vs_cnt_q;
    if (rise) begin
      if (frame_start) vcnt_d = '0;
      else if (vcnt_q != CNT_MAX) vcnt_d = vcnt_q + 11'd1;
      if (frame_start) vs_cnt_d = 11'd1;
      else if (vs_q && vs_cnt_q != CNT_MAX) vs_cnt_d = vs_cnt_q + 11'd1;
    end

    // Line and sync-width checks wait for the first real line start after reset
    line_err    = rise & line_seen_q & ((hcnt_q + 11'd1) != H_LINE);
    fall_err    = fall & line_seen_q & (hcnt_d != H_SYNC);
    timeout_err = ~rise & (hcnt_d == H_LINE);
    frame_err   = frame_start & frame_seen_q
                & (((vcnt_q + 11'd1) != V_FRAME) | (vs_cnt_q != V_SYNC));
    err         = line_err | fall_err | timeout_err | frame_err;
  end

  // Pixel/line counters and first-line/first-frame qualifiers
  always_ff @(posedge FCLK or negedge RST_IN) begin
    if (!RST_IN) begin
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      vs_cnt_q     <= '0;
      vs_line_q    <= 1'b0;
      line_seen_q  <= 1'b0;
      frame_seen_q <= 1'b0;
    end else begin
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      vs_cnt_q     <= vs_cnt_d;
      if (rise) vs_line_q <= vs_q;
      line_seen_q  <= line_seen_q | rise;
      frame_seen_q <= frame_seen_q | frame_start;
    end
  end

  state_t     state_q, state_d;
  logic [3:0] good_q, good_d;

  // Lock FSM state register
  always_ff @(posedge FCLK or negedge RST_IN) begin
    if (!RST_IN) begin
      state_q <= ST_SEARCH;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  // Lock FSM next state: an error always beats a coincident frame start
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    unique case (state_q)
      ST_SEARCH: begin
        if (frame_start && !err) begin
          state_d = ST_VERIFY;
          good_d  = '0;
        end
      end
      ST_VERIFY: begin
        if (err) begin
          state_d = ST_SEARCH;
        end else if (frame_start) begin
          if ((good_q + 4'd1) >= LOCK_N) state_d = ST_LOCKED;
          else good_d = good_q + 4'd1;
        end
      end
      ST_LOCKED: begin
        if (err) state_d = ST_SEARCH;
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  logic        locked_next, visible;
  logic [7:0]  pixel_data_q;
  logic        pixel_valid_q, locked_q, frame_start_q, sync_error_q;
  logic [10:0] pos_x_q, pos_y_q;

  // Visibility of the pixel in the input register, qualified by the lock state it will be reported with
  always_comb begin
    locked_next = (state_d == ST_LOCKED);
    visible     = (hcnt_d >= H_VIS_FIRST) && (hcnt_d <= H_VIS_LAST)
               && (vcnt_d >= V_VIS_FIRST) && (vcnt_d <= V_VIS_LAST);
  end

  // Output register; data and coordinates are forced to zero outside valid pixels
  always_ff @(posedge FCLK or negedge RST_IN) begin
    if (!RST_IN) begin
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      sync_error_q  <= 1'b0;
    end else begin
      pixel_valid_q <= locked_next & visible;
      pixel_data_q  <= (locked_next & visible) ? rgb_q : 8'd0;
      pos_x_q       <= (locked_next & visible) ? (hcnt_d - H_VIS_FIRST) : 11'd0;
      pos_y_q       <= (locked_next & visible) ? (vcnt_d - V_VIS_FIRST) : 11'd0;
      locked_q      <= locked_next;
      frame_start_q <= frame_start & ~err & locked_next;
      sync_error_q  <= err;
    end
  end

  assign PIXEL_DATA  = pixel_data_q;
  assign PIXEL_VALID = pixel_valid_q;
  assign POS_X       = pos_x_q;
  assign POS_Y       = pos_y_q;
  assign LOCKED      = locked_q;
  assign FRAME_START = frame_start_q;
  assign SYNC_ERROR  = sync_error_q;

endmodule
